// File: rtl/score_display_ctrl_if.sv
// Bus between the VGA pipeline and the score readout: frame pulse, score,
// draw position, combinational ROM address/data pairs, and pixel/busy status.
interface score_display_ctrl_if;
  logic        frame_start;
  logic [15:0] score;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [3:0]  label_addr;
  logic [47:0] label_data;
  logic [7:0]  font_addr;
  logic [7:0]  font_data;
  logic        pixel_on;
  logic        busy;

  modport master (
    output frame_start, score, DrawX, DrawY, label_data, font_data,
    input  label_addr, font_addr, pixel_on, busy
  );

  modport slave (
    input  frame_start, score, DrawX, DrawY, label_data, font_data,
    output label_addr, font_addr, pixel_on, busy
  );
endinterface

// File: rtl/score_display_ctrl.sv
// Per-frame score latch, 16-cycle shift-add-3 BCD conversion and "score:" readout
// rendering. Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module score_display_ctrl #(
  parameter logic [9:0] X_ORIGIN = 10'd0,
  parameter logic [9:0] Y_ORIGIN = 10'd0
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  score_display_ctrl_if.slave        bus,
  output logic [1:0]                 dbg_state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, CONVERT = 2'd1, COMMIT = 2'd2} state_t;

  state_t      state_q;
  logic [15:0] shift_q;
  logic [19:0] bcd_q;
  logic [3:0]  count_q;
  logic [19:0] digits_q;
  logic        busy_q;
  logic        pixel_q;

  logic [19:0] bcd_adj;
  logic [10:0] dx, dy;
  logic        in_y, in_label, in_digit;
  logic [5:0]  ddx;
  logic [5:0]  lbit;
  logic [3:0]  row;
  logic [3:0]  digit_sel;
  logic        blank;
  logic [3:0]  lead_zero;
  logic [3:0]  label_addr_d;
  logic [7:0]  font_addr_d;
  logic        pixel_d;

  // Each nibble >= 5 gets +3 before the shift so it carries correctly into the next digit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int n = 0; n < 5; n++) begin
      if (bcd_q[n*4 +: 4] >= 4'd5) bcd_adj[n*4 +: 4] = bcd_q[n*4 +: 4] + 4'd3;
    end
  end

  // Differences are one bit wider so a position left of/above the origin shows up as a set sign bit.
  assign dx       = {1'b0, bus.DrawX} - {1'b0, X_ORIGIN};
  assign dy       = {1'b0, bus.DrawY} - {1'b0, Y_ORIGIN};
  assign in_y     = ~dy[10] && (dy < 11'd16);
  assign in_label = in_y && ~dx[10] && (dx < 11'd48);
  assign in_digit = in_y && ~dx[10] && (dx >= 11'd48) && (dx < 11'd88);
  assign row      = dy[3:0];
  assign ddx      = dx[5:0] - 6'd48;
  assign lbit     = 6'd47 - dx[5:0];

  always_comb begin
    digit_sel = 4'd0;
    blank     = 1'b0;
    lead_zero[0] = (digits_q[19:16] == 4'd0);
    lead_zero[1] = lead_zero[0] && (digits_q[15:12] == 4'd0);
    lead_zero[2] = lead_zero[1] && (digits_q[11:8]  == 4'd0);
    lead_zero[3] = lead_zero[2] && (digits_q[7:4]   == 4'd0);
    case (ddx[5:3])
      3'd0:    begin digit_sel = digits_q[19:16]; blank = lead_zero[0]; end
      3'd1:    begin digit_sel = digits_q[15:12]; blank = lead_zero[1]; end
      3'd2:    begin digit_sel = digits_q[11:8];  blank = lead_zero[2]; end
      3'd3:    begin digit_sel = digits_q[7:4];   blank = lead_zero[3]; end
      default: begin digit_sel = digits_q[3:0];   blank = 1'b0;         end
    endcase
`ifndef LEADING_ZERO_BLANK_EN
    blank = 1'b0;
`endif
  end

  always_comb begin
    label_addr_d = 4'd0;
    font_addr_d  = 8'd0;
    pixel_d      = 1'b0;
    if (in_label) begin
      label_addr_d = 4'd15 - row;
      pixel_d      = bus.label_data[lbit];
    end else if (in_digit && !blank) begin
      font_addr_d  = {digit_sel, row};
      pixel_d      = bus.font_data[3'd7 - ddx[2:0]];
    end
  end

  assign bus.label_addr = label_addr_d;
  assign bus.font_addr  = font_addr_d;
  assign bus.pixel_on   = pixel_q;
  assign bus.busy       = busy_q;
  assign dbg_state_o    = state_q;

  // Handshake: frame_start is a request whose implicit ready is !busy; a pulse
  // arriving while busy is dropped, never queued, and never restarts conversion.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      shift_q  <= 16'd0;
      bcd_q    <= 20'd0;
      count_q  <= 4'd0;
      digits_q <= 20'd0;
      busy_q   <= 1'b0;
      pixel_q  <= 1'b0;
    end else begin
      pixel_q <= pixel_d;
      case (state_q)
        IDLE: begin
          if (bus.frame_start) begin
            shift_q <= bus.score;
            bcd_q   <= 20'd0;
            count_q <= 4'd0;
            busy_q  <= 1'b1;
            state_q <= CONVERT;
          end
        end
        CONVERT: begin
          bcd_q   <= {bcd_adj[18:0], shift_q[15]};
          shift_q <= {shift_q[14:0], 1'b0};
          count_q <= count_q + 4'd1;
          if (count_q == 4'd15) state_q <= COMMIT;
        end
        COMMIT: begin
          digits_q <= bcd_q;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed bench for score_display_ctrl: reset, conversion latency and values,
// ignored frame_start, label/digit rendering, leading-zero behaviour.
module tb_score_display_ctrl;
  localparam logic [9:0] X0 = 10'd0;
  localparam logic [9:0] Y0 = 10'd0;

  logic       Clk;
  logic       Reset_n;
  logic [1:0] dbg_state;
  int         checks;
  int         errors;

  score_display_ctrl_if bus ();

  score_display_ctrl #(.X_ORIGIN(X0), .Y_ORIGIN(Y0)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start(input logic [15:0] s);
    @(negedge Clk);
    bus.score       = s;
    bus.frame_start = 1'b1;
    @(negedge Clk);
    bus.frame_start = 1'b0;
  endtask

  task automatic get_faddr(input int k, output logic [7:0] fa);
    bus.DrawX = X0 + 10'(48 + 8 * k);
    bus.DrawY = Y0 + 10'd3;
    #1;
    fa = bus.font_addr;
  endtask

  task automatic convert(input logic [15:0] s, output int cnt);
    pulse_start(s);
    cnt = 0;
    while (bus.busy && cnt < 100) begin
      cnt++;
      @(negedge Clk);
    end
  endtask

  task automatic test_reset();
    logic [7:0] fa;
    Reset_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      bus.frame_start = ~bus.frame_start;
    end
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++;
    if (bus.pixel_on !== 1'b0) begin errors++; $display("FAIL reset_pixel got %b want 0", bus.pixel_on); end
    checks++;
    if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", dbg_state); end
    bus.frame_start = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (5) @(negedge Clk);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset got %b want 0", bus.busy); end
    get_faddr(4, fa);
    checks++;
    if (fa !== 8'd3) begin errors++; $display("FAIL reset_d0 got %0d want 3", fa); end
    get_faddr(0, fa);
    checks++;
`ifdef LEADING_ZERO_BLANK_EN
    if (fa !== 8'd0) begin errors++; $display("FAIL reset_d4 got %0d want 0", fa); end
`else
    if (fa !== 8'd3) begin errors++; $display("FAIL reset_d4 got %0d want 3", fa); end
`endif
  endtask

  task automatic test_convert_12345();
    int cnt;
    logic [7:0] fa;
    logic [7:0] exp_fa[5];
    exp_fa = '{8'd19, 8'd35, 8'd51, 8'd67, 8'd83};
    convert(16'd12345, cnt);
    checks++;
    if (cnt !== 17) begin errors++; $display("FAIL busy_len_12345 got %0d want 17", cnt); end
    for (int k = 0; k < 5; k++) begin
      get_faddr(k, fa);
      checks++;
      if (fa !== exp_fa[k]) begin errors++; $display("FAIL digit_12345 k=%0d got %0d want %0d", k, fa, exp_fa[k]); end
    end
  endtask

  task automatic test_convert_values();
    int cnt;
    logic [7:0] fa;
    logic [7:0] exp_fa[5];
    exp_fa = '{8'd99, 8'd83, 8'd83, 8'd51, 8'd83};
    convert(16'd65535, cnt);
    for (int k = 0; k < 5; k++) begin
      get_faddr(k, fa);
      checks++;
      if (fa !== exp_fa[k]) begin errors++; $display("FAIL digit_65535 k=%0d got %0d want %0d", k, fa, exp_fa[k]); end
    end
`ifdef LEADING_ZERO_BLANK_EN
    exp_fa = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd3};
`else
    exp_fa = '{8'd3, 8'd3, 8'd3, 8'd3, 8'd3};
`endif
    convert(16'd0, cnt);
    checks++;
    if (cnt !== 17) begin errors++; $display("FAIL busy_len_0 got %0d want 17", cnt); end
    for (int k = 0; k < 5; k++) begin
      get_faddr(k, fa);
      checks++;
      if (fa !== exp_fa[k]) begin errors++; $display("FAIL digit_0 k=%0d got %0d want %0d", k, fa, exp_fa[k]); end
    end
  endtask

  task automatic test_ignore_while_busy();
    int cnt;
    logic [7:0] fa;
    logic [7:0] exp_fa[5];
`ifdef LEADING_ZERO_BLANK_EN
    exp_fa = '{8'd0, 8'd0, 8'd19, 8'd3, 8'd3};
`else
    exp_fa = '{8'd3, 8'd3, 8'd19, 8'd3, 8'd3};
`endif
    pulse_start(16'd100);
    cnt = 0;
    for (int i = 1; i < 40; i++) begin
      if (bus.busy) cnt++;
      if (i == 5) begin bus.score = 16'd999; bus.frame_start = 1'b1; end
      else bus.frame_start = 1'b0;
      @(negedge Clk);
    end
    checks++;
    if (cnt !== 17) begin errors++; $display("FAIL busy_len_ignore got %0d want 17", cnt); end
    for (int k = 0; k < 5; k++) begin
      get_faddr(k, fa);
      checks++;
      if (fa !== exp_fa[k]) begin errors++; $display("FAIL digit_100 k=%0d got %0d want %0d", k, fa, exp_fa[k]); end
    end
  endtask

  task automatic test_label();
    @(negedge Clk);
    bus.label_data = 48'h800000000000;
    bus.font_data  = 8'h00;
    bus.DrawX = X0 + 10'd200;
    bus.DrawY = Y0;
    @(negedge Clk);
    bus.DrawX = X0;
    #1;
    checks++;
    if (bus.label_addr !== 4'd15) begin errors++; $display("FAIL label_addr got %0d want 15", bus.label_addr); end
    checks++;
    if (bus.pixel_on !== 1'b0) begin errors++; $display("FAIL pixel_latency got %b want 0", bus.pixel_on); end
    @(negedge Clk);
    checks++;
    if (bus.pixel_on !== 1'b1) begin errors++; $display("FAIL label_pixel0 got %b want 1", bus.pixel_on); end
    bus.DrawX = X0 + 10'd1;
    @(negedge Clk);
    checks++;
    if (bus.pixel_on !== 1'b0) begin errors++; $display("FAIL label_pixel1 got %b want 0", bus.pixel_on); end
    bus.DrawX = X0 + 10'd88;
    bus.font_data = 8'hFF;
    bus.label_data = '1;
    #1;
    checks++;
    if (bus.font_addr !== 8'd0 || bus.label_addr !== 4'd0) begin
      errors++; $display("FAIL outside_addr got font %0d label %0d want 0 0", bus.font_addr, bus.label_addr);
    end
    @(negedge Clk);
    checks++;
    if (bus.pixel_on !== 1'b0) begin errors++; $display("FAIL outside_pixel got %b want 0", bus.pixel_on); end
    bus.DrawX = X0 + 10'd5;
    bus.DrawY = Y0 + 10'd16;
    #1;
    checks++;
    if (bus.label_addr !== 4'd0) begin errors++; $display("FAIL below_label_addr got %0d want 0", bus.label_addr); end
    bus.DrawY = Y0 + 10'd6;
    #1;
    checks++;
    if (bus.label_addr !== 4'd9) begin errors++; $display("FAIL label_row6 got %0d want 9", bus.label_addr); end
  endtask

  task automatic test_leading_zero();
    int cnt;
    logic want;
    convert(16'd7, cnt);
    bus.font_data = 8'hFF;
    bus.label_data = '0;
    for (int k = 0; k < 5; k++) begin
      bus.DrawX = X0 + 10'(48 + 8 * k + 2);
      bus.DrawY = Y0 + 10'd4;
      @(negedge Clk);
`ifdef LEADING_ZERO_BLANK_EN
      want = (k == 4);
`else
      want = 1'b1;
`endif
      checks++;
      if (bus.pixel_on !== want) begin errors++; $display("FAIL lz_pixel k=%0d got %b want %b", k, bus.pixel_on, want); end
    end
    bus.font_data = 8'h01;
    bus.DrawX = X0 + 10'd87;
    @(negedge Clk);
    checks++;
    if (bus.pixel_on !== 1'b1) begin errors++; $display("FAIL font_bit7 got %b want 1", bus.pixel_on); end
    bus.DrawX = X0 + 10'd86;
    @(negedge Clk);
    checks++;
    if (bus.pixel_on !== 1'b0) begin errors++; $display("FAIL font_bit6 got %b want 0", bus.pixel_on); end
  endtask

  task automatic test_reset_mid_convert();
    int cnt;
    logic [7:0] fa;
    convert(16'd12345, cnt);
    pulse_start(16'd54321);
    repeat (4) @(negedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL abort got busy %b state %0d want 0 0", bus.busy, dbg_state);
    end
    get_faddr(4, fa);
    checks++;
    if (fa !== 8'd3) begin errors++; $display("FAIL abort_d0 got %0d want 3", fa); end
    get_faddr(3, fa);
    checks++;
`ifdef LEADING_ZERO_BLANK_EN
    if (fa !== 8'd0) begin errors++; $display("FAIL abort_d1 got %0d want 0", fa); end
`else
    if (fa !== 8'd3) begin errors++; $display("FAIL abort_d1 got %0d want 3", fa); end
`endif
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset_n = 1'b0;
    bus.frame_start = 1'b0;
    bus.score = 16'd0;
    bus.DrawX = 10'd500;
    bus.DrawY = 10'd400;
    bus.label_data = '0;
    bus.font_data = 8'h00;
    test_reset();
    test_convert_12345();
    test_convert_values();
    test_ignore_while_busy();
    test_label();
    test_leading_zero();
    test_reset_mid_convert();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
